// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative RV32M multiply/divide unit. One shared add/subtract
//               datapath runs WIDTH steps: shift-add for multiplies, restoring
//               division for divides. MULDIV_FAST_PATH_EN enables a 2-cycle
//               short-cut for divide-by-zero, signed overflow and zero operands.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic             accept, advance, step, finish;
    logic [CW-1:0]    count;
    logic [2:0]       op_q;
    logic             a_neg, b_neg, div_zero_q, skip;
    logic [WIDTH-1:0] hi, lo, opnd;

    // ------------------------------------------------------------------
    // Operand preparation at acceptance
    // ------------------------------------------------------------------
    logic             a_signed, b_signed, sa, sb, div_zero, shortcut;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign sa       = a_signed & a[WIDTH-1];
    assign sb       = b_signed & b[WIDTH-1];
    assign a_mag    = sa ? (~a + 1'b1) : a;
    assign b_mag    = sb ? (~b + 1'b1) : b;
    assign div_zero = op[2] && (b == '0);

`ifdef MULDIV_FAST_PATH_EN
    logic ovf;
    assign ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                      (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign shortcut = div_zero || ovf || (!op[2] && ((a == '0) || (b == '0)));
`else
    assign shortcut = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shared adder: hi + multiplicand, or shifted remainder - divisor
    // ------------------------------------------------------------------
    logic             sub;
    logic [WIDTH:0]   add_x;
    logic [WIDTH+1:0] add_y, sum;

    assign sub   = op_q[2];
    assign add_x = sub ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    assign add_y = sub ? ~{2'b00, opnd} : {2'b00, opnd};
    assign sum   = {1'b0, add_x} + add_y + {{(WIDTH+1){1'b0}}, sub};

    // ------------------------------------------------------------------
    // Sign correction and special cases
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fixed;

    assign prod     = {hi, lo};
    assign prod_fix = (a_neg ^ b_neg) ? (~prod + 1'b1) : prod;
    assign quo_fix  = (a_neg ^ b_neg) ? (~lo + 1'b1) : lo;
    assign rem_fix  = a_neg ? (~hi + 1'b1) : hi;

    always_comb begin
        fixed = '0;
        unique case (op_q)
            OP_MUL:                       fixed = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fixed = div_zero_q ? '1 : quo_fix;
            OP_REM, OP_REMU:              fixed = rem_fix;
            default:                      fixed = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        accept   = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_ITER;
                end
            end
            S_ITER: begin
                busy    = 1'b1;
                advance = 1'b1;
                if (count == LAST_CNT) state_nx = S_FIX;
            end
            S_FIX: begin
                busy     = 1'b1;
                finish   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Short-cut operations pass through one frozen ITER cycle so that
    // completion still lands two edges after acceptance.
    assign step = advance && !skip;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count      <= '0;
            op_q       <= '0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            div_zero_q <= 1'b0;
            skip       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                op_q       <= op;
                a_neg      <= sa;
                b_neg      <= sb;
                div_zero_q <= div_zero;
                skip       <= shortcut;
                count      <= shortcut ? LAST_CNT : '0;
                hi         <= '0;
                lo         <= op[2] ? a_mag : b_mag;
                opnd       <= op[2] ? b_mag : a_mag;
                if (shortcut) begin
                    // Preload registers so the normal fix-up yields the answer
                    if (div_zero)    hi <= a_mag;
                    else if (!op[2]) lo <= '0;
                end
            end else if (advance) begin
                count <= count + CNT_ONE;
                if (step) begin
                    if (sub) begin
                        if (!sum[WIDTH+1]) begin
                            hi <= sum[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= add_x[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b0};
                        end
                    end else if (lo[0]) begin
                        {hi, lo} <= {sum[WIDTH:0], lo[WIDTH-1:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
                    end
                end
            end
            if (finish) result <= fixed;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Randomised self-checking bench for muldiv_sequencer against an
//               arithmetic reference model (honours MULDIV_FAST_PATH_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam logic [31:0] MIN_INT = 32'h8000_0000;
`ifdef MULDIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] xs, ys;
        logic        [63:0] xu, yu, p;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        xu = {32'd0, x};
        yu = {32'd0, y};
        case (o)
            3'd0: begin p = xu * yu; return p[31:0]; end
            3'd1: begin p = xs * ys; return p[63:32]; end
            3'd2: begin p = xs * $signed(yu); return p[63:32]; end
            3'd3: begin p = xu * yu; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN_INT && y == 32'hFFFF_FFFF) return MIN_INT;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN_INT && y == 32'hFFFF_FFFF) return 32'd0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit quick;
        if (o[2]) quick = (y == 0) || (!o[0] && x == MIN_INT && y == 32'hFFFF_FFFF);
        else      quick = (x == 0) || (y == 0);
        return (FAST && quick) ? 2 : 33;
    endfunction

    // Issues one operation starting in the current cycle. With disturb set, a
    // second start with different operands is held high while the unit is busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit disturb);
        logic [31:0] expv;
        int          lat, want_lat;
        bit          busy_bad, early_done;
        expv       = model(o, x, y);
        want_lat   = exp_latency(o, x, y);
        busy_bad   = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        early_done = done;
        start = disturb;
        if (disturb) begin
            op = ~o; a = $urandom; b = $urandom;
        end
        lat = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check_val($sformatf("latency op%0d", o), lat, want_lat);
        check_val($sformatf("result op%0d a=%08h b=%08h", o, x, y), result, expv);
        check_val("busy_held", {31'd0, busy_bad}, 32'd0);
        check_val("busy_low_at_done", {31'd0, busy}, 32'd0);
        check_val("done_single_pulse", {31'd0, early_done}, 32'd0);
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    initial begin
        vec_t        dir[$];
        bit          bad;
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result", result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy || done || result != 0) bad = 1'b1;
        end
        check_val("idle_quiet", {31'd0, bad}, 32'd0);

        dir = '{
            '{3'd0, 32'hFFFF_FFFF, 32'd2}, '{3'd1, 32'hFFFF_FFFF, 32'd2},
            '{3'd3, 32'hFFFF_FFFF, 32'd2}, '{3'd2, 32'hFFFF_FFFF, 32'd2},
            '{3'd4, 32'hFFFF_FFF9, 32'd2}, '{3'd6, 32'hFFFF_FFF9, 32'd2},
            '{3'd5, 32'hFFFF_FFF9, 32'd2}, '{3'd7, 32'hFFFF_FFF9, 32'd2},
            '{3'd4, 32'd5, 32'd0},         '{3'd7, 32'd5, 32'd0},
            '{3'd4, MIN_INT, 32'hFFFF_FFFF}, '{3'd6, MIN_INT, 32'hFFFF_FFFF},
            '{3'd6, 32'hFFFF_FFF9, 32'd0}, '{3'd1, 32'd0, 32'h1234_5678}
        };
        // Back-to-back calls also start each operation in the previous done cycle
        foreach (dir[i]) run_op(dir[i].o, dir[i].x, dir[i].y, 1'b0);

        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1);

        for (int i = 0; i < 48; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 9))
                0: ry = 32'd0;
                1: begin rx = MIN_INT; ry = 32'hFFFF_FFFF; end
                2: rx = 32'd0;
                3: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, rx, ry, i[0]);
        end

        // Reset in the middle of a DIVU
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = $urandom; b = $urandom | 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_done", {31'd0, done}, 32'd0);
        check_val("midrst_result", result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || done || result != 0) bad = 1'b1;
        end
        check_val("midrst_no_done", {31'd0, bad}, 32'd0);
        run_op(3'd5, 32'd1000, 32'd7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
